// File: rtl/wb_tx_message_queue.sv
// Transmit message queue: a producer writes bus chunks grouped into messages; the bus
// master replays the head message chunk by chunk (with rewind) and frees it when done.
module wb_tx_message_queue #(
  parameter int ADDR_W              = 32,
  parameter int DATA_W              = 32,
  parameter int SEL_W               = 4,
  parameter int N_BITS_BURST_LENGHT = 7,
  parameter int CHUNK_AW            = 4,
  parameter int MSG_AW              = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  // Producer handshake: a chunk transfers on a clk edge where wr_valid_i && wr_ready_o;
  // wr_ready_o never depends on wr_valid_i, and a refused chunk must be held by the producer.
  input  logic                           wr_valid_i,
  output logic                           wr_ready_o,
  input  logic [ADDR_W-1:0]              wr_address_i,
  input  logic [DATA_W-1:0]              wr_data_i,
  input  logic [SEL_W-1:0]               wr_sel_i,
  input  logic                           wr_we_i,
  input  logic                           wr_last_i,
  output logic                           r_bus_arbitration_o,
  output logic [ADDR_W-1:0]              address_o,
  output logic [DATA_W-1:0]              data_o,
  output logic [SEL_W-1:0]               sel_o,
  output logic                           transaction_type_o,
  output logic [N_BITS_BURST_LENGHT-1:0] burst_lenght_o,
  input  logic                           next_data_i,
  input  logic                           message_transmitted_i,
  input  logic                           retry_i,
  output logic                           empty_o,
  output logic                           full_o
);
  localparam int DEPTH     = 1 << CHUNK_AW;
  localparam int MSG_DEPTH = 1 << MSG_AW;
  localparam int LW = ((CHUNK_AW > N_BITS_BURST_LENGHT) ? CHUNK_AW : N_BITS_BURST_LENGHT) + 1;
  // A message reaching the largest encodable length is closed even without wr_last_i.
  localparam logic [N_BITS_BURST_LENGHT-1:0] ACC_SPLIT = {{(N_BITS_BURST_LENGHT-1){1'b1}}, 1'b0};

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [SEL_W-1:0]  sel;
    logic              we;
  } chunk_t;

  chunk_t                         mem_q     [DEPTH];
  logic [N_BITS_BURST_LENGHT-1:0] len_mem_q [MSG_DEPTH];

  logic [CHUNK_AW-1:0]            wr_ptr_q, wr_ptr_d, head_ptr_q, head_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CHUNK_AW:0]              used_q, used_d;
  logic [N_BITS_BURST_LENGHT-1:0] acc_q, acc_d;
  logic [MSG_AW-1:0]              msg_wr_q, msg_wr_d, msg_rd_q, msg_rd_d;
  logic [MSG_AW:0]                msg_count_q, msg_count_d;

  logic                           wr_fire, msg_push, has_msg, msg_free, can_advance;
  logic [N_BITS_BURST_LENGHT-1:0] head_len;
  logic [CHUNK_AW-1:0]            rd_off;
  chunk_t                         wr_chunk, rd_chunk;

  assign wr_ready_o          = !rst && !used_q[CHUNK_AW] && !msg_count_q[MSG_AW];
  assign empty_o             = (used_q == '0);
  assign full_o              = used_q[CHUNK_AW];
  assign has_msg             = (msg_count_q != '0);
  assign r_bus_arbitration_o = has_msg;

  assign rd_chunk           = mem_q[rd_ptr_q];
  assign head_len           = len_mem_q[msg_rd_q];
  assign address_o          = rd_chunk.addr;
  assign data_o             = rd_chunk.data;
  assign sel_o              = rd_chunk.sel;
  assign transaction_type_o = rd_chunk.we;
  assign burst_lenght_o     = head_len;

  always_comb begin
    wr_chunk    = {wr_address_i, wr_data_i, wr_sel_i, wr_we_i};
    wr_fire     = wr_valid_i && wr_ready_o;
    msg_push    = wr_fire && (wr_last_i || (acc_q == ACC_SPLIT));
    msg_free    = message_transmitted_i && has_msg;
    rd_off      = rd_ptr_q - head_ptr_q;
    can_advance = has_msg && ((LW'(rd_off) + LW'(1)) < LW'(head_len));

    wr_ptr_d    = wr_ptr_q;
    acc_d       = acc_q;
    msg_wr_d    = msg_wr_q;
    if (wr_fire) begin
      wr_ptr_d = wr_ptr_q + CHUNK_AW'(1);
      acc_d    = msg_push ? '0 : acc_q + N_BITS_BURST_LENGHT'(1);
    end
    if (msg_push) msg_wr_d = msg_wr_q + MSG_AW'(1);

    // Freeing outranks rewinding, which outranks stepping.
    head_ptr_d = head_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    msg_rd_d   = msg_rd_q;
    if (msg_free) begin
      head_ptr_d = head_ptr_q + CHUNK_AW'(head_len);
      rd_ptr_d   = head_ptr_d;
      msg_rd_d   = msg_rd_q + MSG_AW'(1);
    end else if (retry_i) begin
      rd_ptr_d = head_ptr_q;
    end else if (next_data_i && can_advance) begin
      rd_ptr_d = rd_ptr_q + CHUNK_AW'(1);
    end

    used_d = used_q;
    if (wr_fire)  used_d = used_d + (CHUNK_AW+1)'(1);
    if (msg_free) used_d = used_d - (CHUNK_AW+1)'(head_len);

    msg_count_d = msg_count_q;
    if (msg_push) msg_count_d = msg_count_d + (MSG_AW+1)'(1);
    if (msg_free) msg_count_d = msg_count_d - (MSG_AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (wr_fire)  mem_q[wr_ptr_q]     <= wr_chunk;
    if (msg_push) len_mem_q[msg_wr_q] <= acc_q + N_BITS_BURST_LENGHT'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      head_ptr_q  <= '0;
      rd_ptr_q    <= '0;
      used_q      <= '0;
      acc_q       <= '0;
      msg_wr_q    <= '0;
      msg_rd_q    <= '0;
      msg_count_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      head_ptr_q  <= head_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      used_q      <= used_d;
      acc_q       <= acc_d;
      msg_wr_q    <= msg_wr_d;
      msg_rd_q    <= msg_rd_d;
      msg_count_q <= msg_count_d;
    end
  end
endmodule

// File: tb/tb_wb_tx_message_queue.sv
// Bench for wb_tx_message_queue: queue-based reference model feeding a scoreboard,
// directed scenarios plus random traffic, and a wide-buffer instance for length splitting.
`timescale 1ns/1ps
module tb_wb_tx_message_queue;
  localparam int AW = 32, DW = 32, SW = 4, NB = 7;
  localparam int DEPTH = 16, MSG_DEPTH = 4, MAX_LEN = 127;

  logic          clk, rst;
  logic          wr_valid_i, wr_ready_o, wr_we_i, wr_last_i;
  logic [AW-1:0] wr_address_i, address_o;
  logic [DW-1:0] wr_data_i, data_o;
  logic [SW-1:0] wr_sel_i, sel_o;
  logic          r_bus_arbitration_o, transaction_type_o;
  logic [NB-1:0] burst_lenght_o;
  logic          next_data_i, message_transmitted_i, retry_i, empty_o, full_o;

  logic          b_rst, b_wr_valid_i, b_wr_ready_o, b_wr_last_i;
  logic [AW-1:0] b_wr_address_i, b_address_o;
  logic [DW-1:0] b_data_o;
  logic [SW-1:0] b_sel_o;
  logic          b_arb, b_tt, b_next, b_mt, b_retry, b_empty, b_full;
  logic [NB-1:0] b_burst;

  wb_tx_message_queue dut (
    .clk(clk), .rst(rst), .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
    .wr_address_i(wr_address_i), .wr_data_i(wr_data_i), .wr_sel_i(wr_sel_i),
    .wr_we_i(wr_we_i), .wr_last_i(wr_last_i), .r_bus_arbitration_o(r_bus_arbitration_o),
    .address_o(address_o), .data_o(data_o), .sel_o(sel_o),
    .transaction_type_o(transaction_type_o), .burst_lenght_o(burst_lenght_o),
    .next_data_i(next_data_i), .message_transmitted_i(message_transmitted_i),
    .retry_i(retry_i), .empty_o(empty_o), .full_o(full_o)
  );

  wb_tx_message_queue #(.CHUNK_AW(8)) dut_big (
    .clk(clk), .rst(b_rst), .wr_valid_i(b_wr_valid_i), .wr_ready_o(b_wr_ready_o),
    .wr_address_i(b_wr_address_i), .wr_data_i(32'h0), .wr_sel_i(4'h0),
    .wr_we_i(1'b1), .wr_last_i(b_wr_last_i), .r_bus_arbitration_o(b_arb),
    .address_o(b_address_o), .data_o(b_data_o), .sel_o(b_sel_o),
    .transaction_type_o(b_tt), .burst_lenght_o(b_burst),
    .next_data_i(b_next), .message_transmitted_i(b_mt),
    .retry_i(b_retry), .empty_o(b_empty), .full_o(b_full)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [SW-1:0] sel;
    logic          we;
  } chunk_t;

  typedef struct packed {
    logic          ready;
    logic          arb;
    logic          empty;
    logic          full;
    logic [NB-1:0] burst;
    chunk_t        cur;
  } exp_t;

  exp_t   exp_q[$];
  chunk_t m_chunks[$];  // stored chunks, oldest (head message) first
  int     m_lens[$];    // lengths of completed messages, head first
  int     m_acc, m_rd;
  int     checks, errors;

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_step();
    int blen;
    bit fire;
    if (rst) begin
      m_chunks.delete();
      m_lens.delete();
      m_acc = 0;
      m_rd  = 0;
      return;
    end
    fire = wr_valid_i && (m_chunks.size() < DEPTH) && (m_lens.size() < MSG_DEPTH);
    blen = (m_lens.size() != 0) ? m_lens[0] : 0;
    if (message_transmitted_i && blen != 0) begin
      for (int i = 0; i < blen; i++) void'(m_chunks.pop_front());
      void'(m_lens.pop_front());
      m_rd = 0;
    end else if (retry_i) begin
      m_rd = 0;
    end else if (next_data_i && blen != 0 && m_rd < blen - 1) begin
      m_rd++;
    end
    if (fire) begin
      m_chunks.push_back({wr_address_i, wr_data_i, wr_sel_i, wr_we_i});
      m_acc++;
      if (wr_last_i || m_acc == MAX_LEN) begin
        m_lens.push_back(m_acc);
        m_acc = 0;
      end
    end
  endtask

  function automatic exp_t model_snapshot();
    exp_t e;
    e       = '0;
    e.ready = !rst && (m_chunks.size() < DEPTH) && (m_lens.size() < MSG_DEPTH);
    e.arb   = (m_lens.size() != 0);
    e.empty = (m_chunks.size() == 0);
    e.full  = (m_chunks.size() == DEPTH);
    if (e.arb) begin
      e.burst = NB'(m_lens[0]);
      e.cur   = m_chunks[m_rd];
    end
    return e;
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(posedge clk) begin : mon
    exp_t e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("wr_ready", 64'(wr_ready_o), 64'(e.ready));
      check("arb", 64'(r_bus_arbitration_o), 64'(e.arb));
      check("empty", 64'(empty_o), 64'(e.empty));
      check("full", 64'(full_o), 64'(e.full));
      if (e.arb) begin
        check("burst", 64'(burst_lenght_o), 64'(e.burst));
        check("address", 64'(address_o), 64'(e.cur.addr));
        check("data", 64'(data_o), 64'(e.cur.data));
        check("sel", 64'(sel_o), 64'(e.cur.sel));
        check("we", 64'(transaction_type_o), 64'(e.cur.we));
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic drive(input bit v, input bit l, input logic [AW-1:0] a,
                       input bit nx, input bit mt, input bit rt, input bit r);
    rst                   = r;
    wr_valid_i            = v;
    wr_last_i             = l;
    wr_address_i          = a;
    wr_data_i             = $urandom;
    wr_sel_i              = SW'($urandom_range(0, 15));
    wr_we_i               = 1'($urandom_range(0, 1));
    next_data_i           = nx;
    message_transmitted_i = mt;
    retry_i               = rt;
    model_step();
    @(posedge clk);
    exp_q.push_back(model_snapshot());
    @(negedge clk);
  endtask

  task automatic wr(input bit l, input logic [AW-1:0] a);
    drive(1'b1, l, a, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic ctl(input bit nx, input bit mt, input bit rt);
    drive(1'b0, 1'b0, '0, nx, mt, rt, 1'b0);
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    ctl(1'b0, 1'b0, 1'b0);
  endtask

  task automatic b_cycle(input bit v, input bit l, input logic [AW-1:0] a, input bit mt, input bit r);
    b_rst          = r;
    b_wr_valid_i   = v;
    b_wr_last_i    = l;
    b_wr_address_i = a;
    b_mt           = mt;
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    checks = 0; errors = 0; m_acc = 0; m_rd = 0;
    rst = 1'b1; wr_valid_i = 1'b0; wr_last_i = 1'b0; wr_address_i = '0; wr_data_i = '0;
    wr_sel_i = '0; wr_we_i = 1'b0; next_data_i = 1'b0; message_transmitted_i = 1'b0;
    retry_i = 1'b0;
    b_rst = 1'b1; b_wr_valid_i = 1'b0; b_wr_last_i = 1'b0; b_wr_address_i = '0;
    b_next = 1'b0; b_mt = 1'b0; b_retry = 1'b0;

    // Reset state
    do_reset();
    check("rst_ready", 64'(wr_ready_o), 64'd1);
    check("rst_empty", 64'(empty_o), 64'd1);
    check("rst_full", 64'(full_o), 64'd0);
    check("rst_arb", 64'(r_bus_arbitration_o), 64'd0);

    // Message A: not offered until its last chunk, then stepped and clamped
    wr(1'b0, 32'hA0);
    wr(1'b0, 32'hA1);
    check("partial_arb", 64'(r_bus_arbitration_o), 64'd0);
    wr(1'b1, 32'hA2);
    check("msg_a_arb", 64'(r_bus_arbitration_o), 64'd1);
    check("msg_a_burst", 64'(burst_lenght_o), 64'd3);
    check("msg_a_addr0", 64'(address_o), 64'hA0);
    ctl(1'b1, 1'b0, 1'b0);
    check("step_a1", 64'(address_o), 64'hA1);
    ctl(1'b1, 1'b0, 1'b0);
    check("step_a2", 64'(address_o), 64'hA2);
    ctl(1'b1, 1'b0, 1'b0);
    check("hold_a2", 64'(address_o), 64'hA2);

    // Retry rewinds; free beats retry and exposes message B
    wr(1'b0, 32'hB0);
    wr(1'b1, 32'hB1);
    ctl(1'b0, 1'b0, 1'b1);
    check("retry_a0", 64'(address_o), 64'hA0);
    ctl(1'b1, 1'b0, 1'b0);
    ctl(1'b1, 1'b0, 1'b0);
    ctl(1'b0, 1'b0, 1'b1);
    check("retry2_a0", 64'(address_o), 64'hA0);
    ctl(1'b0, 1'b1, 1'b1);
    check("free_b0", 64'(address_o), 64'hB0);
    check("free_b_burst", 64'(burst_lenght_o), 64'd2);

    // Fill to full, free concurrently with a write, then wrap the pointers
    do_reset();
    for (int i = 0; i < 3; i++) wr(i == 2, 32'hC0 + i);
    for (int i = 0; i < 3; i++) wr(i == 2, 32'hF0 + i);
    for (int i = 0; i < 10; i++) wr(1'b0, 32'hD0 + i);
    check("fill_full", 64'(full_o), 64'd1);
    check("fill_ready", 64'(wr_ready_o), 64'd0);
    wr(1'b1, 32'h99);
    check("reject_full", 64'(full_o), 64'd1);
    ctl(1'b0, 1'b1, 1'b0);
    check("free_c_full", 64'(full_o), 64'd0);
    check("free_c_addr", 64'(address_o), 64'hF0);
    drive(1'b1, 1'b0, 32'hDA, 1'b0, 1'b1, 1'b0, 1'b0);
    check("wr_free_arb", 64'(r_bus_arbitration_o), 64'd0);
    for (int i = 1; i < 5; i++) wr(1'b0, 32'hDA + i);
    check("refill_15", 64'(full_o), 64'd0);
    wr(1'b1, 32'hDF);
    check("refill_16", 64'(full_o), 64'd1);
    check("msg_d_burst", 64'(burst_lenght_o), 64'd16);
    check("msg_d_addr0", 64'(address_o), 64'hD0);
    for (int i = 0; i < 16; i++) ctl(1'b1, 1'b0, 1'b0);
    check("wrap_last", 64'(address_o), 64'hDF);
    ctl(1'b0, 1'b1, 1'b0);
    check("drained_empty", 64'(empty_o), 64'd1);

    // Message table full
    do_reset();
    for (int i = 0; i < 4; i++) wr(1'b1, 32'h40 + i);
    check("tbl_ready", 64'(wr_ready_o), 64'd0);
    check("tbl_full", 64'(full_o), 64'd0);
    wr(1'b1, 32'h4F);
    ctl(1'b0, 1'b1, 1'b0);
    check("tbl_free_ready", 64'(wr_ready_o), 64'd1);
    check("tbl_next_addr", 64'(address_o), 64'h41);

    // Reset mid-message discards everything
    do_reset();
    wr(1'b0, 32'h50);
    wr(1'b1, 32'h51);
    wr(1'b0, 32'h52);
    ctl(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 32'h53, 1'b1, 1'b0, 1'b0, 1'b1);
    check("mid_rst_empty", 64'(empty_o), 64'd1);
    check("mid_rst_arb", 64'(r_bus_arbitration_o), 64'd0);
    check("mid_rst_ready", 64'(wr_ready_o), 64'd0);
    ctl(1'b0, 1'b0, 1'b0);
    wr(1'b1, 32'h60);
    check("post_rst_addr", 64'(address_o), 64'h60);
    check("post_rst_burst", 64'(burst_lenght_o), 64'd1);

    // Random traffic against the model
    for (int n = 0; n < 1500; n++)
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3, $urandom,
            $urandom_range(0, 9) < 4, $urandom_range(0, 19) < 3,
            $urandom_range(0, 9) == 0, $urandom_range(0, 199) == 0);

    // Forced split of an over-long message on the wide instance
    b_cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
    b_cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 126; i++) b_cycle(1'b1, 1'b0, 32'h1000 + i, 1'b0, 1'b0);
    check("split_pre_arb", 64'(b_arb), 64'd0);
    b_cycle(1'b1, 1'b0, 32'h1000 + 126, 1'b0, 1'b0);
    check("split_arb", 64'(b_arb), 64'd1);
    check("split_len127", 64'(b_burst), 64'd127);
    check("split_addr0", 64'(b_address_o), 64'h1000);
    for (int i = 127; i < 130; i++) b_cycle(1'b1, i == 129, 32'h1000 + i, 1'b0, 1'b0);
    check("split_head_kept", 64'(b_burst), 64'd127);
    b_cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
    check("split_len3", 64'(b_burst), 64'd3);
    check("split_addr127", 64'(b_address_o), 64'h107F);
    check("split_arb2", 64'(b_arb), 64'd1);

    @(posedge clk);
    #2;
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
